// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/sequencing controller for the 5-stage ARM pipeline: load-use bubble, branch squash, operand forwarding.
// Optional performance counters are built when HAZARD_PERF_CNT_EN is defined.
module pipeline_hazard_ctrl #(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       id_rn,
  input  logic [3:0]       id_rm,
  input  logic [3:0]       id_rd,
  input  logic             id_use_rn,
  input  logic             id_use_rm,
  input  logic             id_use_rd,
  input  logic [3:0]       ex_rd,
  input  logic [3:0]       mem_rd,
  input  logic [3:0]       wb_rd,
  input  logic             ex_rf_e,
  input  logic             mem_rf_e,
  input  logic             wb_rf_e,
  input  logic             ex_load,
  input  logic             ex_branch_taken,
  output logic             enable_pc,
  output logic             enable_ifid,
  output logic             S,
  output logic             flush_ifid,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [1:0]       fwd_c,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10,
    BAD   = 2'b11
  } state_t;

  localparam logic [1:0] FLUSH_LOAD = 2'(FLUSH_CYCLES - 1);

  state_t     cur_state, nxt_state;
  logic [1:0] flush_cnt, flush_cnt_nxt;
  logic       load_use;

  // Youngest producer wins; a load still in EX cannot forward yet, so it reads as RF.
  function automatic logic [1:0] fwd_sel(
    input logic       use_r,
    input logic [3:0] r,
    input logic [3:0] e_rd, input logic e_rf_e, input logic e_load,
    input logic [3:0] m_rd, input logic m_rf_e,
    input logic [3:0] w_rd, input logic w_rf_e
  );
    logic [1:0] sel;
    sel = 2'b00;
    if (use_r && r != 4'd15) begin
      if (e_rf_e && e_rd == r)      sel = e_load ? 2'b00 : 2'b01;
      else if (m_rf_e && m_rd == r) sel = 2'b10;
      else if (w_rf_e && w_rd == r) sel = 2'b11;
    end
    return sel;
  endfunction

  assign load_use = ex_load & ex_rf_e & (
      (id_use_rn & (ex_rd == id_rn) & (id_rn != 4'd15)) |
      (id_use_rm & (ex_rd == id_rm) & (id_rm != 4'd15)) |
      (id_use_rd & (ex_rd == id_rd) & (id_rd != 4'd15)));

  always_comb begin
    // NOTE: every signal gets a default first so no path through this block can infer a latch.
    enable_pc     = 1'b1;
    enable_ifid   = 1'b1;
    S             = 1'b0;
    flush_ifid    = 1'b0;
    nxt_state     = cur_state;
    flush_cnt_nxt = flush_cnt;

    if (ex_branch_taken) begin
      flush_ifid = 1'b1;
      S          = 1'b1;
      if (FLUSH_CYCLES > 1) begin
        nxt_state     = FLUSH;
        flush_cnt_nxt = FLUSH_LOAD;
      end else begin
        nxt_state     = RUN;
        flush_cnt_nxt = 2'd0;
      end
    end else begin
      unique case (cur_state)
        RUN: begin
          if (load_use) begin
            enable_pc   = 1'b0;
            enable_ifid = 1'b0;
            S           = 1'b1;
            nxt_state   = STALL;
          end
        end
        STALL: nxt_state = RUN;
        FLUSH: begin
          flush_ifid = 1'b1;
          S          = 1'b1;
          if (flush_cnt <= 2'd1) begin
            nxt_state     = RUN;
            flush_cnt_nxt = 2'd0;
          end else begin
            flush_cnt_nxt = flush_cnt - 2'd1;
          end
        end
        default: begin
          nxt_state     = RUN;
          flush_cnt_nxt = 2'd0;
        end
      endcase
    end

    // Reset overrides the Mealy outputs: pipeline frozen with a NOP in ID.
    if (reset) begin
      enable_pc   = 1'b0;
      enable_ifid = 1'b0;
      S           = 1'b1;
      flush_ifid  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_state <= RUN;
      flush_cnt <= 2'd0;
    end else begin
      cur_state <= nxt_state;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  assign state = cur_state;

  assign fwd_a = reset ? 2'b00 : fwd_sel(id_use_rn, id_rn, ex_rd, ex_rf_e, ex_load,
                                          mem_rd, mem_rf_e, wb_rd, wb_rf_e);
  assign fwd_b = reset ? 2'b00 : fwd_sel(id_use_rm, id_rm, ex_rd, ex_rf_e, ex_load,
                                          mem_rd, mem_rf_e, wb_rd, wb_rf_e);
  assign fwd_c = reset ? 2'b00 : fwd_sel(id_use_rd, id_rd, ex_rd, ex_rf_e, ex_load,
                                          mem_rd, mem_rf_e, wb_rd, wb_rf_e);

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_q, flush_q;
  logic             stall_evt;

  assign stall_evt = (cur_state == RUN) & ~ex_branch_taken & load_use;

  // Saturating counters: hold at all-ones instead of wrapping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && stall_q != '1)       stall_q <= stall_q + CNT_W'(1);
      if (ex_branch_taken && flush_q != '1) flush_q <= flush_q + CNT_W'(1);
    end
  end

  assign stall_count = stall_q;
  assign flush_count = flush_q;
`else
  assign stall_count = '0;
  assign flush_count = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench: three controllers (FLUSH_CYCLES = 1, 2, 3) driven in parallel and compared
// every cycle against a behavioural model; directed scenarios first, then random traffic.
module tb_pipeline_hazard_ctrl;
  localparam int CNT_W = 16;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd;
  logic       id_use_rn, id_use_rm, id_use_rd;
  logic       ex_rf_e, mem_rf_e, wb_rf_e, ex_load, ex_branch_taken;

  logic             en_pc[3], en_ifid[3], s_mux[3], flush[3];
  logic [1:0]       fa[3], fb[3], fc[3], st[3];
  logic [CNT_W-1:0] scnt[3], fcnt[3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    pipeline_hazard_ctrl #(.FLUSH_CYCLES(g + 1), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .id_rn(id_rn), .id_rm(id_rm), .id_rd(id_rd),
      .id_use_rn(id_use_rn), .id_use_rm(id_use_rm), .id_use_rd(id_use_rd),
      .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
      .ex_rf_e(ex_rf_e), .mem_rf_e(mem_rf_e), .wb_rf_e(wb_rf_e),
      .ex_load(ex_load), .ex_branch_taken(ex_branch_taken),
      .enable_pc(en_pc[g]), .enable_ifid(en_ifid[g]), .S(s_mux[g]), .flush_ifid(flush[g]),
      .fwd_a(fa[g]), .fwd_b(fb[g]), .fwd_c(fc[g]), .state(st[g]),
      .stall_count(scnt[g]), .flush_count(fcnt[g])
    );
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Model: remaining squash cycles, whether a bubble was just inserted, and event counts.
  int m_flush_left[3];
  bit m_bubbled[3];
  int m_stalls[3];
  int m_flushes[3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_fwd(input logic use_r, input logic [3:0] r);
    if (!use_r || r == 4'd15)      return 2'd0;
    if (ex_rf_e && ex_rd == r)     return ex_load ? 2'd0 : 2'd1;
    if (mem_rf_e && mem_rd == r)   return 2'd2;
    if (wb_rf_e && wb_rd == r)     return 2'd3;
    return 2'd0;
  endfunction

  function automatic bit model_hazard();
    bit h;
    h = 1'b0;
    if (ex_load && ex_rf_e) begin
      if (id_use_rn && id_rn != 4'd15 && id_rn == ex_rd) h = 1'b1;
      if (id_use_rm && id_rm != 4'd15 && id_rm == ex_rd) h = 1'b1;
      if (id_use_rd && id_rd != 4'd15 && id_rd == ex_rd) h = 1'b1;
    end
    return h;
  endfunction

  function automatic int sat(input int v);
    return (v >= (1 << CNT_W) - 1) ? (1 << CNT_W) - 1 : v + 1;
  endfunction

  task automatic check_all();
    logic       e_pc, e_ifid, e_s, e_fl;
    logic [1:0] e_st;
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        m_flush_left[i] = 0;
        m_bubbled[i]    = 1'b0;
        m_stalls[i]     = 0;
        m_flushes[i]    = 0;
      end
      e_st = (m_flush_left[i] > 0) ? 2'd2 : (m_bubbled[i] ? 2'd1 : 2'd0);
      if (reset)                                      {e_pc, e_ifid, e_s, e_fl} = 4'b0010;
      else if (ex_branch_taken)                       {e_pc, e_ifid, e_s, e_fl} = 4'b1111;
      else if (m_flush_left[i] > 0)                   {e_pc, e_ifid, e_s, e_fl} = 4'b1111;
      else if (!m_bubbled[i] && model_hazard())       {e_pc, e_ifid, e_s, e_fl} = 4'b0010;
      else                                            {e_pc, e_ifid, e_s, e_fl} = 4'b1100;
      check($sformatf("enable_pc[fc%0d]", i + 1), 32'(en_pc[i]), 32'(e_pc));
      check($sformatf("enable_ifid[fc%0d]", i + 1), 32'(en_ifid[i]), 32'(e_ifid));
      check($sformatf("S[fc%0d]", i + 1), 32'(s_mux[i]), 32'(e_s));
      check($sformatf("flush_ifid[fc%0d]", i + 1), 32'(flush[i]), 32'(e_fl));
      check($sformatf("state[fc%0d]", i + 1), 32'(st[i]), 32'(e_st));
      check($sformatf("fwd_a[fc%0d]", i + 1), 32'(fa[i]),
            reset ? 32'd0 : 32'(model_fwd(id_use_rn, id_rn)));
      check($sformatf("fwd_b[fc%0d]", i + 1), 32'(fb[i]),
            reset ? 32'd0 : 32'(model_fwd(id_use_rm, id_rm)));
      check($sformatf("fwd_c[fc%0d]", i + 1), 32'(fc[i]),
            reset ? 32'd0 : 32'(model_fwd(id_use_rd, id_rd)));
`ifdef HAZARD_PERF_CNT_EN
      check($sformatf("stall_count[fc%0d]", i + 1), 32'(scnt[i]), 32'(m_stalls[i]));
      check($sformatf("flush_count[fc%0d]", i + 1), 32'(fcnt[i]), 32'(m_flushes[i]));
`else
      check($sformatf("stall_count[fc%0d]", i + 1), 32'(scnt[i]), 32'd0);
      check($sformatf("flush_count[fc%0d]", i + 1), 32'(fcnt[i]), 32'd0);
`endif
    end
  endtask

  task automatic advance();
    bit hz;
    hz = model_hazard();
    if (reset) return;
    for (int i = 0; i < 3; i++) begin
      if (ex_branch_taken) begin
        m_flush_left[i] = i;   // FLUSH_CYCLES - 1 further squash cycles
        m_bubbled[i]    = 1'b0;
        m_flushes[i]    = sat(m_flushes[i]);
      end else if (m_flush_left[i] > 0) begin
        m_flush_left[i]--;
        m_bubbled[i] = 1'b0;
      end else if (!m_bubbled[i] && hz) begin
        m_bubbled[i] = 1'b1;
        m_stalls[i]  = sat(m_stalls[i]);
      end else begin
        m_bubbled[i] = 1'b0;
      end
    end
  endtask

  // Inputs are set just after a falling edge; outputs checked 1 ns later, model steps on the rising edge.
  task automatic cycle();
    #1;
    check_all();
    @(posedge clk);
    advance();
    @(negedge clk);
  endtask

  task automatic set_idle();
    {id_rn, id_rm, id_rd, ex_rd, mem_rd, wb_rd} = '0;
    {id_use_rn, id_use_rm, id_use_rd} = '0;
    {ex_rf_e, mem_rf_e, wb_rf_e, ex_load, ex_branch_taken} = '0;
  endtask

  function automatic logic [3:0] rand_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 3));
  endfunction

  task automatic set_random();
    id_rn = rand_reg(); id_rm = rand_reg(); id_rd = rand_reg();
    ex_rd = rand_reg(); mem_rd = rand_reg(); wb_rd = rand_reg();
    id_use_rn = 1'($urandom); id_use_rm = 1'($urandom); id_use_rd = 1'($urandom);
    ex_rf_e = 1'($urandom); mem_rf_e = 1'($urandom); wb_rf_e = 1'($urandom);
    ex_load = 1'($urandom);
    ex_branch_taken = ($urandom_range(0, 7) == 0);
  endtask

  initial begin
    set_idle();
    reset = 1'b1;
    @(negedge clk);

    // Reset held three cycles, then released with no hazards.
    repeat (3) cycle();
    reset = 1'b0;
    cycle();
    cycle();

    // Load-use on rn, then the bubble cycle with the load now in MEM.
    ex_load = 1'b1; ex_rf_e = 1'b1; ex_rd = 4'd2; id_rn = 4'd2; id_use_rn = 1'b1;
    #1 check("lu_enable_pc", 32'(en_pc[0]), 32'd0);
    cycle();
    ex_load = 1'b0; ex_rf_e = 1'b0; mem_rd = 4'd2; mem_rf_e = 1'b1;
    #1 check("lu_state_stall", 32'(st[0]), 32'd1);
    check("lu_fwd_a_mem", 32'(fa[0]), 32'd2);
    cycle();
    set_idle();
    cycle();

    // Forwarding priority on rm.
    ex_rd = 4'd5; ex_rf_e = 1'b1; mem_rd = 4'd5; mem_rf_e = 1'b1; wb_rd = 4'd5; wb_rf_e = 1'b1;
    id_rm = 4'd5; id_use_rm = 1'b1;
    cycle();
    ex_rf_e = 1'b0;  cycle();
    mem_rf_e = 1'b0; cycle();
    id_rm = 4'd15;   cycle();
    set_idle();
    cycle();

    // Taken-branch pulse, then idle while the squash drains.
    ex_branch_taken = 1'b1;
    cycle();
    ex_branch_taken = 1'b0;
    #1 check("br_fc2_state_flush", 32'(st[1]), 32'd2);
    repeat (3) cycle();

    // Branch together with a load-use hazard: branch wins.
    ex_branch_taken = 1'b1; ex_load = 1'b1; ex_rf_e = 1'b1; ex_rd = 4'd3; id_rd = 4'd3; id_use_rd = 1'b1;
    cycle();
    set_idle();
    repeat (3) cycle();

    // Reset asserted in the middle of a FLUSH on the three-cycle instance.
    ex_branch_taken = 1'b1;
    cycle();
    ex_branch_taken = 1'b0;
    #2;
    reset = 1'b1;
    #1 check("rst_mid_flush_state", 32'(st[2]), 32'd0);
    cycle();
    reset = 1'b0;
    cycle();
    cycle();

    // Random traffic with occasional asynchronous resets.
    for (int n = 0; n < 800; n++) begin
      set_random();
      reset = ($urandom_range(0, 63) == 0);
      cycle();
    end
    reset = 1'b0;
    set_idle();
    cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
